// File: rtl/ram_defs.sv
// Shared RAM geometry and requester IDs for the RAM8 arbiter slice.
package ram_defs;
  localparam int RAM_AW = 3;
  localparam int RAM_DW = 16;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;
endpackage

// File: rtl/RAM8.sv
// 8-word RAM: synchronous write on load, asynchronous read of the addressed word.
module RAM8
  import ram_defs::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic [RAM_AW-1:0] address,
  input  logic [RAM_DW-1:0] in,
  output logic [RAM_DW-1:0] out
);
  // Contents are deliberately left unreset.
  logic [RAM_DW-1:0] r_mem [1<<RAM_AW];

  always_ff @(posedge clk) begin
    if (load) r_mem[address] <= in;
  end

  assign out = r_mem[address];
endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin two-port arbiter with bounded lock in front of one RAM8.
// Handshake: a port holds req/we/addr/wdata stable until it sees gnt high; the access completes that cycle.
module ram8_arbiter
  import ram_defs::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [RAM_AW-1:0] addr0,
  input  logic [RAM_AW-1:0] addr1,
  input  logic [RAM_DW-1:0] wdata0,
  input  logic [RAM_DW-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [RAM_DW-1:0] rdata
);
  port_e             r_prio;
  port_e             r_last;
  logic [3:0]        r_burst_cnt;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [RAM_DW-1:0] r_rdata;

  logic              w_lock_hold;
  port_e             w_win;
  logic              w_gnt0;
  logic              w_gnt1;
  port_e             w_gnt_port;
  logic              w_other_req;
  logic              w_load;
  logic [RAM_AW-1:0] w_address;
  logic [RAM_DW-1:0] w_in;
  logic [RAM_DW-1:0] w_ram_out;

  always_comb begin
    w_lock_hold = 1'b0;
    w_win       = r_prio;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_address   = '0;
    w_in        = '0;
    w_load      = 1'b0;

    // The port granted last cycle keeps the grant while locking, up to MAX_BURST.
    if (r_last == PORT0) w_lock_hold = req0 && lock0 && (r_burst_cnt < 4'(MAX_BURST));
    else                 w_lock_hold = req1 && lock1 && (r_burst_cnt < 4'(MAX_BURST));

    if (req0 && req1) begin
      w_win  = w_lock_hold ? r_last : r_prio;
      w_gnt0 = (w_win == PORT0);
      w_gnt1 = (w_win == PORT1);
    end else begin
      w_gnt0 = req0;
      w_gnt1 = req1;
    end

    if (w_gnt0) begin
      w_address = addr0;
      w_in      = wdata0;
      w_load    = we0;
    end else if (w_gnt1) begin
      w_address = addr1;
      w_in      = wdata1;
      w_load    = we1;
    end

    // Reset is asynchronous, so a write on an edge where reset is high must not land.
    w_load = w_load && !reset;
  end

  assign w_gnt_port  = w_gnt1 ? PORT1 : PORT0;
  assign w_other_req = w_gnt0 ? req1 : req0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio      <= PORT0;
      r_last      <= PORT0;
      r_burst_cnt <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 && !we0;
      r_rvalid1 <= w_gnt1 && !we1;
      if (w_gnt0 || w_gnt1) begin
        r_prio      <= w_gnt0 ? PORT1 : PORT0;
        r_last      <= w_gnt_port;
        r_burst_cnt <= (w_gnt_port == r_last && w_other_req) ? r_burst_cnt + 4'd1 : 4'd1;
        if (!w_load) r_rdata <= w_ram_out;
      end else begin
        r_burst_cnt <= '0;
      end
    end
  end

  RAM8 u_ram (
    .clk     (clk),
    .load    (w_load),
    .address (w_address),
    .in      (w_in),
    .out     (w_ram_out)
  );

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;
endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter: grant checks per cycle, read data via an expected queue.
module tb_ram8_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, we0, we1, lock0, lock1;
  logic [2:0]   addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0] rdata;

  ram8_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem_m [8];
  logic         pend_v0 = 1'b0;
  logic         pend_v1 = 1'b0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [2:0] a0, input logic [W-1:0] d0,
                       input logic r1, input logic w1, input logic [2:0] a1, input logic [W-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // One clock cycle: checks the previous grant's read result and this cycle's grant,
  // then updates the bench's memory model and expected queue.
  task automatic cycle(input logic eg0, input logic eg1, input string tag);
    logic [W-1:0] e;
    @(negedge clk);
    chk({tag, ".rvalid0"}, {15'd0, rvalid0}, {15'd0, pend_v0});
    chk({tag, ".rvalid1"}, {15'd0, rvalid1}, {15'd0, pend_v1});
    if (pend_v0 || pend_v1) begin
      if (exp_q.size() == 0) chk({tag, ".queue_empty"}, 16'd0, 16'd1);
      else begin
        e = exp_q.pop_front();
        chk({tag, ".rdata"}, rdata, e);
      end
    end
    chk({tag, ".gnt0"}, {15'd0, gnt0}, {15'd0, eg0});
    chk({tag, ".gnt1"}, {15'd0, gnt1}, {15'd0, eg1});
    pend_v0 = 1'b0;
    pend_v1 = 1'b0;
    if (!reset) begin
      if (eg0 && !we0) begin pend_v0 = 1'b1; exp_q.push_back(mem_m[addr0]); end
      if (eg1 && !we1) begin pend_v1 = 1'b1; exp_q.push_back(mem_m[addr1]); end
      if (eg0 && we0) mem_m[addr0] = wdata0;
      if (eg1 && we1) mem_m[addr1] = wdata1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    lock0 = 1'b0; lock1 = 1'b0;
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
    for (int i = 0; i < 8; i++) mem_m[i] = 'x;

    // Power-on reset state
    #2;
    chk("por.rvalid0", {15'd0, rvalid0}, 16'd0);
    chk("por.rvalid1", {15'd0, rvalid1}, 16'd0);
    chk("por.rdata", rdata, 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Single-port writes then reads
    drive(1, 1, 3'd0, 16'h1111, 0, 0, 3'd0, 16'h0); cycle(1, 0, "wr0");
    drive(1, 1, 3'd1, 16'h2222, 0, 0, 3'd0, 16'h0); cycle(1, 0, "wr1");
    drive(1, 1, 3'd5, 16'h5555, 0, 0, 3'd0, 16'h0); cycle(1, 0, "wr5");
    drive(1, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(1, 0, "rd0");
    drive(1, 0, 3'd1, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(1, 0, "rd1");
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(0, 0, "idle_a");

    // Reset mid-operation: pending rvalid is dropped, write under reset is suppressed
    drive(1, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(1, 0, "rd_pre_rst");
    reset = 1'b1;
    #1;
    chk("mid_rst.rvalid0", {15'd0, rvalid0}, 16'd0);
    chk("mid_rst.rdata", rdata, 16'h0000);
    pend_v0 = 1'b0; pend_v1 = 1'b0;
    exp_q.delete();
    drive(1, 1, 3'd5, 16'hBEEF, 0, 0, 3'd0, 16'h0); cycle(1, 0, "wr_in_rst");
    reset = 1'b0;

    // Contention, round-robin starting from port 0 after reset
    drive(1, 0, 3'd0, 16'h0, 1, 0, 3'd1, 16'h0);
    cycle(1, 0, "rr0"); cycle(0, 1, "rr1"); cycle(1, 0, "rr2"); cycle(0, 1, "rr3");
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(0, 0, "idle_b");

    // RAM survives reset and the write during reset did not land
    drive(1, 0, 3'd5, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(1, 0, "rd5");

    // Cross-port hazard: port 1 write wins (prio=1), port 0 read of same word next cycle
    drive(1, 0, 3'd1, 16'h0, 1, 1, 3'd1, 16'hAAAA); cycle(0, 1, "hz_wr");
    drive(1, 0, 3'd1, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(1, 0, "hz_rd");
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(0, 0, "idle_c");

    // Lock/burst with both ports requesting: 4x port 0, then port 1, repeating
    lock0 = 1'b1;
    drive(1, 0, 3'd0, 16'h0, 1, 0, 3'd2, 16'h0);
    mem_m[2] = 16'h0;
    // word 2 was never written; give it a defined value through port 1 first
    lock0 = 1'b0;
    drive(0, 0, 3'd0, 16'h0, 1, 1, 3'd2, 16'h3C3C); cycle(0, 1, "wr2");
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(0, 0, "idle_d");
    lock0 = 1'b1;
    drive(1, 0, 3'd0, 16'h0, 1, 0, 3'd2, 16'h0);
    // last=1 with lock1 low, prio=0 -> port 0 takes the first grant and starts its burst
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, "burst_a"); cycle(1, 0, "burst_b"); cycle(1, 0, "burst_c"); cycle(1, 0, "burst_d");
      cycle(0, 1, "burst_yield");
    end
    cycle(1, 0, "burst_resume");
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(0, 0, "idle_e");

    // Lock with idle peer: port 0 keeps the grant every cycle
    drive(1, 0, 3'd1, 16'h0, 0, 0, 3'd0, 16'h0);
    for (int k = 0; k < 10; k++) cycle(1, 0, "lock_idle");
    lock0 = 1'b0;
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);    cycle(0, 0, "idle_f");
    chk("final.queue_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram8_arbiter.md
# ram8_arbiter

Two-port arbiter and sequencer in front of one 8-word × 16-bit `RAM8` instance, so two requesters (e.g. CPU data path and a DMA/loader) can share it. Each cycle it grants at most one request using round-robin priority with an optional bounded lock (burst) per port. It drives the `RAM8` `load`/`address`/`in` pins and returns registered read data with a valid strobe one cycle after grant.

## Interface
- `MAX_BURST`, 4: maximum consecutive grants to one locking port while the other port is requesting; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req0`, `req1` input 1 each: port N requests an access this cycle.
- `we0`, `we1` input 1 each: 1 = write, 0 = read; valid while `reqN`.
- `lock0`, `lock1` input 1 each: port N asks to keep the grant on following cycles.
- `addr0`, `addr1` input 3 each: word address.
- `wdata0`, `wdata1` input 16 each: write data.
- `gnt0`, `gnt1` output 1 each: combinational grant; at most one is high.
- `rvalid0`, `rvalid1` output 1 each: registered read-data strobe.
- `rdata` output 16: registered read data, shared by both ports and qualified by `rvalidN`.

## Operation
- **Grant rule:**
  - Only one requester: that requester wins.
  - Both requesting: the port named by priority pointer `prio` (0/1) wins, unless the lock rule applies.
- **Lock rule:** applies when `last` (the port granted last cycle) is requesting with `lockN` high and `burst_cnt < MAX_BURST`. That port wins regardless of `prio`.
- **On each grant to port N:**
  - `prio` becomes 1−N.
  - `burst_cnt` increments if N == `last` and the other port is requesting; otherwise it becomes 1.
  - `last` becomes N.
- **On a cycle with no grant:** `burst_cnt` becomes 0 and `last` is held.
- **RAM drive:**
  - `address` = granted `addrN`, else 0.
  - `in` = granted `wdataN`, else 0.
  - `load` = granted `weN`, else 0.
- **Granted read:** at the closing edge, `rdata` captures RAM `out` and `rvalidN` goes high for exactly one cycle.
- **Granted write:** commits at the closing edge; `rvalid` stays 0 and `rdata` holds its value.
- **Requests and handshake:** requests are not queued. A requester holds `req`/`we`/`addr`/`wdata` stable until it samples `gnt` high; the access completes in that same cycle.
- **Reset values:**
  - `prio` = 0, `last` = 0, `burst_cnt` = 0.
  - `rvalid0`/`rvalid1` = 0, `rdata` = 16'h0000.
  - `gnt*` follow the inputs combinationally; `load` is 0 while `reset` is high.
  - RAM contents are not cleared.

## Timing
- **Grant:** 0-cycle, combinational from `req*`, `lock*` and the registered `prio`/`last`/`burst_cnt`.
- **Write latency:** data is visible to a read granted in the next cycle. A read-after-write from either port in cycle N+1 returns the new value.
- **Read latency:** 1 cycle. A grant in cycle N gives `rvalidN` and `rdata` in cycle N+1. Back-to-back reads yield one `rvalid` per cycle.
- **Simultaneous read on one port and write on the other:** only the granted access happens; the loser retries next cycle with the other port's priority.
- **`burst_cnt` == `MAX_BURST`:** the lock is ignored for one arbitration and the other port wins if requesting. If the other port is idle, the locking port continues and the count restarts at 1.
- **Reset mid-operation:** any pending `rvalid` is cleared immediately. A write in the cycle where `reset` asserts is suppressed, because `load` is forced to 0.

## Structure
- Shared package/include `ram_defs`: `RAM_AW` = 3, `RAM_DW` = 16, and port IDs `PORT0`/`PORT1`.
- Single sub-module: existing `RAM8` (ports `clk`, `load`, `address`, `in`, `out`), instantiated once as `u_ram`.
- **Registers:** `prio`, `last`, `burst_cnt` (4 bits), `rvalid0`, `rvalid1`, `rdata`.
- **Combinational logic:** grant logic and the RAM-drive mux.

## Test plan
- **Reset:** `reset` pulse mid-run → `rvalid*` = 0, `rdata` = 0, and the first contended grant goes to port 0.
- **Single-port write/read:** port 0 writes 16'h1111@0 and 16'h2222@1, then reads @0 and @1 → `gnt0` each cycle; `rvalid0` with `rdata` = 1111 then 2222, one cycle after each read grant.
- **Contention round-robin:** both ports request reads every cycle (port0@0, port1@1) → grants alternate 0,1,0,1; `rvalid` alternates and `rdata` alternates 1111/2222.
- **Cross-port hazard:** port 1 writes 16'hAAAA@1 in cycle N while port 0 requests read@1 → port 0 is granted in N+1 and gets `rdata` = AAAA in N+2.
- **Lock/burst:** `lock0` = 1 with both ports requesting continuously, `MAX_BURST` = 4 → exactly 4 consecutive `gnt0`, then `gnt1`, then port 0 again.
- **Lock with idle peer:** `lock0` = 1, `req1` = 0 for 10 cycles → `gnt0` on all 10 cycles, and `gnt1` is never asserted.
